// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit seven-segment display controller:
// register indices, FSM state type and the hex glyph table ({g,f,e,d,c,b,a}, 1 = lit).
package seg7_pkg;

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegCtrl   = 2'd1;
    localparam logic [1:0] RegStatus = 2'd2;

    typedef enum logic [1:0] {
        StShow0 = 2'd0,
        StGap0  = 2'd1,
        StShow1 = 2'd2,
        StGap1  = 2'd3
    } state_e;

    localparam logic [6:0] HexGlyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to seven-segment glyph lookup.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] segments_o
);

    assign segments_o = HexGlyph[nibble_i];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped two-digit seven-segment controller with refresh multiplexing.
// Define SEG7_DEADTIME_EN to insert blank gap states between digit switches.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1024,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  io_addr,
    input  logic        io_wstrb,
    input  logic [31:0] io_wdata,
    input  logic        io_rstrb,
    output logic [31:0] io_rdata,
    output logic [6:0]  segment_display,
    output logic        segment_select
);

    localparam int unsigned MaxCnt = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt);
    localparam logic [CntW-1:0] ShowLast = CntW'(REFRESH_DIV - 1);
`ifdef SEG7_DEADTIME_EN
    localparam logic [CntW-1:0] GapLast  = CntW'(DEAD_CYCLES - 1);
`endif

    logic [13:0]     data_q, data_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [6:0]      disp_q, disp_d;
    logic            sel_q, sel_d;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [6:0] glyph0, glyph1, digit0, digit1;
    logic       gap_active;
    logic       unused_wdata;

    assign unused_wdata = ^io_wdata[31:14];

    seg7_hex_decoder u_dec0 (
        .nibble_i   (data_q[3:0]),
        .segments_o (glyph0)
    );

    seg7_hex_decoder u_dec1 (
        .nibble_i   (data_q[7:4]),
        .segments_o (glyph1)
    );

`ifdef SEG7_DEADTIME_EN
    assign gap_active = (state_q == StGap0) || (state_q == StGap1);
`else
    assign gap_active = 1'b0;
`endif

    // Raw mode bypasses the decoders; blanking of a zero upper nibble is hex-only.
    assign digit0 = ctrl_q[1] ? data_q[6:0] : glyph0;
    assign digit1 = ctrl_q[1] ? data_q[13:7] :
                    (ctrl_q[2] && (data_q[7:4] == 4'h0)) ? 7'h00 : glyph1;

    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        rdata_d = rdata_q;
        if (io_wstrb) begin
            case (io_addr)
                RegData: data_d = io_wdata[13:0];
                RegCtrl: ctrl_d = io_wdata[2:0];
                default: ;
            endcase
        end
        if (io_rstrb) begin
            case (io_addr)
                RegData:   rdata_d = {18'b0, data_q};
                RegCtrl:   rdata_d = {29'b0, ctrl_q};
                RegStatus: rdata_d = {30'b0, gap_active, sel_q};
                default:   rdata_d = 32'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        if (!ctrl_q[0]) begin
            state_d = StShow0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StShow0: if (cnt_q == ShowLast) begin
                    cnt_d = '0;
`ifdef SEG7_DEADTIME_EN
                    state_d = StGap0;
`else
                    state_d = StShow1;
`endif
                end
                StShow1: if (cnt_q == ShowLast) begin
                    cnt_d = '0;
`ifdef SEG7_DEADTIME_EN
                    state_d = StGap1;
`else
                    state_d = StShow0;
`endif
                end
`ifdef SEG7_DEADTIME_EN
                StGap0: if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StShow1;
                end
                StGap1: if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StShow0;
                end
`endif
                default: begin
                    cnt_d   = '0;
                    state_d = StShow0;
                end
            endcase
        end
    end

    // Outputs follow the current state, so they trail the FSM by one cycle.
    always_comb begin
        disp_d = 7'h00;
        sel_d  = 1'b0;
        if (ctrl_q[0]) begin
            case (state_q)
                StShow0: disp_d = digit0;
                StShow1: begin
                    disp_d = digit1;
                    sel_d  = 1'b1;
                end
                StGap0:  sel_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_q  <= '0;
            ctrl_q  <= '0;
            rdata_q <= '0;
            disp_q  <= '0;
            sel_q   <= 1'b0;
            state_q <= StShow0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            disp_q  <= disp_d;
            sel_q   <= sel_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign io_rdata        = rdata_q;
    assign segment_display = disp_q;
    assign segment_select  = sel_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl with REFRESH_DIV=4, DEAD_CYCLES=2.
// Gap expectations follow whether SEG7_DEADTIME_EN is defined for the build.
module tb_seg7_display_ctrl;

    localparam int unsigned Div = 4;
`ifdef SEG7_DEADTIME_EN
    localparam int unsigned Gap = 2;
    localparam logic [31:0] StatGap0a = 32'h2;
    localparam logic [31:0] StatGap0b = 32'h3;
`else
    localparam int unsigned Gap = 0;
    localparam logic [31:0] StatGap0a = 32'h0;
    localparam logic [31:0] StatGap0b = 32'h1;
`endif

    logic        CLK;
    logic        RESET;
    logic [1:0]  io_addr;
    logic        io_wstrb;
    logic [31:0] io_wdata;
    logic        io_rstrb;
    logic [31:0] io_rdata;
    logic [6:0]  segment_display;
    logic        segment_select;

    int n_vec;
    int n_miss;

    seg7_display_ctrl #(
        .REFRESH_DIV (Div),
        .DEAD_CYCLES (2)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .io_addr         (io_addr),
        .io_wstrb        (io_wstrb),
        .io_wdata        (io_wdata),
        .io_rstrb        (io_rstrb),
        .io_rdata        (io_rdata),
        .segment_display (segment_display),
        .segment_select  (segment_select)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        io_addr  = a;
        io_wdata = d;
        io_wstrb = 1'b1;
        tick();
        io_wstrb = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        io_addr  = a;
        io_rstrb = 1'b1;
        tick();
        io_rstrb = 1'b0;
        check(tag, io_rdata, exp);
    endtask

    // Disable, load DATA, then enable with the given CTRL so the FSM starts cleanly in SHOW0.
    task automatic restart(input logic [31:0] data, input logic [31:0] ctrl);
        wr(2'd1, 32'h0);
        wr(2'd0, data);
        wr(2'd1, ctrl);
        check("pre_enable_blank", {25'b0, segment_display}, 32'h0);
    endtask

    task automatic show_cycle(input logic [6:0] e0, input logic [6:0] e1, input string tag);
        for (int i = 0; i < Div; i++) begin
            tick();
            check({tag, "_d0"}, {25'b0, segment_display}, {25'b0, e0});
            check({tag, "_sel0"}, {31'b0, segment_select}, 32'h0);
        end
        for (int i = 0; i < Gap; i++) begin
            tick();
            check({tag, "_gap0"}, {25'b0, segment_display}, 32'h0);
        end
        for (int i = 0; i < Div; i++) begin
            tick();
            check({tag, "_d1"}, {25'b0, segment_display}, {25'b0, e1});
            check({tag, "_sel1"}, {31'b0, segment_select}, 32'h1);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        RESET    = 1'b1;
        io_addr  = 2'd0;
        io_wstrb = 1'b0;
        io_wdata = 32'h0;
        io_rstrb = 1'b0;

        tick();
        tick();
        check("rst_disp", {25'b0, segment_display}, 32'h0);
        check("rst_sel", {31'b0, segment_select}, 32'h0);
        check("rst_rdata", io_rdata, 32'h0);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_disp", {25'b0, segment_display}, 32'h0);
            check("idle_sel", {31'b0, segment_select}, 32'h0);
        end

        // Hex 0x3A: 'A' right, '3' left, then wraps back to digit 0.
        restart(32'h3A, 32'h1);
        show_cycle(7'b1110111, 7'b1001111, "hex3a");
        for (int i = 0; i < Gap; i++) begin
            tick();
            check("hex3a_gap1", {25'b0, segment_display}, 32'h0);
        end
        tick();
        check("hex3a_wrap_d0", {25'b0, segment_display}, 32'h77);
        check("hex3a_wrap_sel", {31'b0, segment_select}, 32'h0);

        restart(32'h05, 32'h5);
        show_cycle(7'b1101101, 7'b0000000, "lzs05");

        restart(32'h05, 32'h1);
        show_cycle(7'b1101101, 7'b0111111, "nolzs05");

        restart(32'h1555, 32'h3);
        show_cycle(7'b1010101, 7'b0101010, "raw1555");

        wr(2'd0, 32'h1234ABCD);
        rd(2'd0, 32'h00002BCD, "rd_data");
        rd(2'd1, 32'h00000003, "rd_ctrl");
        rd(2'd3, 32'h0, "rd_idx3");
        wr(2'd2, 32'hFFFFFFFF);
        rd(2'd0, 32'h00002BCD, "rd_data_after_status_wr");

        // Simultaneous write and read of DATA returns the old value.
        io_addr  = 2'd0;
        io_wdata = 32'h0077;
        io_wstrb = 1'b1;
        io_rstrb = 1'b1;
        tick();
        io_wstrb = 1'b0;
        io_rstrb = 1'b0;
        check("rw_same_old", io_rdata, 32'h00002BCD);
        rd(2'd0, 32'h00000077, "rw_same_new");

        // STATUS right after leaving SHOW0: select lags the state by one cycle.
        restart(32'h3A, 32'h1);
        for (int i = 0; i < Div; i++) tick();
        rd(2'd2, StatGap0a, "status_a");
        rd(2'd2, StatGap0b, "status_b");

        // Asynchronous reset while digit 1 is shown.
        restart(32'h3A, 32'h1);
        for (int i = 0; i < Div + Gap + 1; i++) tick();
        check("pre_rst_show1", {25'b0, segment_display}, 32'h4F);
        check("pre_rst_sel1", {31'b0, segment_select}, 32'h1);
        #2;
        RESET = 1'b1;
        #1;
        check("mid_rst_disp", {25'b0, segment_display}, 32'h0);
        check("mid_rst_sel", {31'b0, segment_select}, 32'h0);
        check("mid_rst_rdata", io_rdata, 32'h0);
        tick();
        RESET = 1'b0;
        rd(2'd0, 32'h0, "post_rst_data");
        rd(2'd1, 32'h0, "post_rst_ctrl");
        tick();
        check("post_rst_disp", {25'b0, segment_display}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
